// File: rtl/sdram_cmd_arbiter_if.sv
// ============================================================================
// sdram_cmd_arbiter_if : engine request/grant and SDRAM command bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface sdram_cmd_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
);
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;
  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;
  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;
  logic              aref_en;
  logic              wr_en;
  logic              rd_en;
  logic [3:0]        sdram_cmd;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;

  // Arbiter side
  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en, sdram_cmd, sdram_ba, sdram_addr
  );

  // Engine / pin side
  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en, sdram_cmd, sdram_ba, sdram_addr
  );
endinterface

`default_nettype wire

// File: rtl/sdram_cmd_arbiter.sv
// ============================================================================
// sdram_cmd_arbiter : grants the SDRAM command bus to init/refresh/write/read.
// Optional macro SDRAM_ARB_RR_EN: round-robin between write and read.
// Rev 1.0
// ============================================================================
`default_nettype none

module sdram_cmd_arbiter #(
  parameter int         ADDR_W  = 13,
  parameter int         BA_W    = 2,
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  sdram_cmd_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

`ifdef SDRAM_ARB_RR_EN
  // 1 = read was the most recent burst granted
  logic last_rd_q, last_rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_rd_q <= 1'b1;
    else        last_rd_q <= last_rd_d;
  end
`endif

  always_comb begin
    state_d = state_q;
`ifdef SDRAM_ARB_RR_EN
    last_rd_d = last_rd_q;
`endif
    case (state_q)
      S_INIT:  if (bus.init_end) state_d = S_IDLE;
      S_IDLE: begin
        if (bus.aref_req) begin
          state_d = S_AREF;
        end else if (bus.wr_req && bus.rd_req) begin
`ifdef SDRAM_ARB_RR_EN
          state_d = last_rd_q ? S_WRITE : S_READ;
`else
          state_d = S_WRITE;
`endif
        end else if (bus.wr_req) begin
          state_d = S_WRITE;
        end else if (bus.rd_req) begin
          state_d = S_READ;
        end
      end
      S_AREF:  if (bus.aref_end) state_d = S_IDLE;
      S_WRITE: if (bus.wr_end)   state_d = S_IDLE;
      S_READ:  if (bus.rd_end)   state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
`ifdef SDRAM_ARB_RR_EN
    if (state_q == S_IDLE && state_d == S_WRITE) last_rd_d = 1'b0;
    if (state_q == S_IDLE && state_d == S_READ)  last_rd_d = 1'b1;
`endif
  end

  // Outputs decode the registered state only, so an async reset clears them at once
  always_comb begin
    bus.aref_en    = 1'b0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.sdram_cmd  = CMD_NOP;
    bus.sdram_ba   = '1;
    bus.sdram_addr = '1;
    case (state_q)
      S_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_ba   = bus.init_ba;
        bus.sdram_addr = bus.init_addr;
      end
      S_AREF: begin
        bus.aref_en    = 1'b1;
        bus.sdram_cmd  = bus.aref_cmd;
        bus.sdram_ba   = bus.aref_ba;
        bus.sdram_addr = bus.aref_addr;
      end
      S_WRITE: begin
        bus.wr_en      = 1'b1;
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_ba   = bus.wr_ba;
        bus.sdram_addr = bus.wr_addr;
      end
      S_READ: begin
        bus.rd_en      = 1'b1;
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_ba   = bus.rd_ba;
        bus.sdram_addr = bus.rd_addr;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_cmd_arbiter.sv
// ============================================================================
// tb_sdram_cmd_arbiter : randomized bench against a rule-level owner model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sdram_cmd_arbiter;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;

  // Bus owner codes used by the reference model
  localparam int OW_INIT = 0;
  localparam int OW_IDLE = 1;
  localparam int OW_AREF = 2;
  localparam int OW_WR   = 3;
  localparam int OW_RD   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_cmd_arbiter_if #(.ADDR_W(ADDR_W), .BA_W(BA_W)) arb_if ();

  sdram_cmd_arbiter #(
    .ADDR_W (ADDR_W),
    .BA_W   (BA_W),
    .CMD_NOP(4'b0111)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (arb_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int owner    = OW_INIT;
  int last_win = OW_RD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (owner %0d, t=%0t)", tag, obs, exp, owner, $time);
    end
  endtask

  function automatic int next_owner(int cur);
    case (cur)
      OW_INIT: return arb_if.init_end ? OW_IDLE : OW_INIT;
      OW_IDLE: begin
        if (arb_if.aref_req) return OW_AREF;
        if (arb_if.wr_req && arb_if.rd_req) begin
`ifdef SDRAM_ARB_RR_EN
          return (last_win == OW_WR) ? OW_RD : OW_WR;
`else
          return OW_WR;
`endif
        end
        if (arb_if.wr_req) return OW_WR;
        if (arb_if.rd_req) return OW_RD;
        return OW_IDLE;
      end
      OW_AREF: return arb_if.aref_end ? OW_IDLE : OW_AREF;
      OW_WR:   return arb_if.wr_end   ? OW_IDLE : OW_WR;
      OW_RD:   return arb_if.rd_end   ? OW_IDLE : OW_RD;
      default: return OW_INIT;
    endcase
  endfunction

  task automatic compare_outputs(input string pfx);
    logic [2:0]        g;
    logic [3:0]        c;
    logic [BA_W-1:0]   b;
    logic [ADDR_W-1:0] a;
    g = {owner == OW_AREF, owner == OW_WR, owner == OW_RD};
    case (owner)
      OW_INIT: begin c = arb_if.init_cmd; b = arb_if.init_ba; a = arb_if.init_addr; end
      OW_AREF: begin c = arb_if.aref_cmd; b = arb_if.aref_ba; a = arb_if.aref_addr; end
      OW_WR:   begin c = arb_if.wr_cmd;   b = arb_if.wr_ba;   a = arb_if.wr_addr;   end
      OW_RD:   begin c = arb_if.rd_cmd;   b = arb_if.rd_ba;   a = arb_if.rd_addr;   end
      default: begin c = 4'b0111; b = '1; a = '1; end
    endcase
    chk({pfx, "_grants"}, 32'({arb_if.aref_en, arb_if.wr_en, arb_if.rd_en}), 32'(g));
    chk({pfx, "_cmd"},  32'(arb_if.sdram_cmd),  32'(c));
    chk({pfx, "_ba"},   32'(arb_if.sdram_ba),   32'(b));
    chk({pfx, "_addr"}, 32'(arb_if.sdram_addr), 32'(a));
  endtask

  // Called just after a rising edge: check mid-cycle, then advance the model on the next edge
  task automatic step(input string pfx);
    int nxt;
    @(negedge clk);
    compare_outputs(pfx);
    @(posedge clk);
    nxt = next_owner(owner);
    if (owner == OW_IDLE && (nxt == OW_WR || nxt == OW_RD)) last_win = nxt;
    owner = nxt;
    #1;
  endtask

  task automatic rand_bus();
    arb_if.init_cmd  = 4'($urandom);  arb_if.init_ba = BA_W'($urandom);  arb_if.init_addr = ADDR_W'($urandom);
    arb_if.aref_cmd  = 4'($urandom);  arb_if.aref_ba = BA_W'($urandom);  arb_if.aref_addr = ADDR_W'($urandom);
    arb_if.wr_cmd    = 4'($urandom);  arb_if.wr_ba   = BA_W'($urandom);  arb_if.wr_addr   = ADDR_W'($urandom);
    arb_if.rd_cmd    = 4'($urandom);  arb_if.rd_ba   = BA_W'($urandom);  arb_if.rd_addr   = ADDR_W'($urandom);
  endtask

  task automatic rand_ctrl();
    arb_if.init_end = 1'($urandom);
    arb_if.aref_req = ($urandom_range(0, 5) == 0);
    arb_if.wr_req   = 1'($urandom);
    arb_if.rd_req   = 1'($urandom);
    arb_if.aref_end = ($urandom_range(0, 3) == 0);
    arb_if.wr_end   = ($urandom_range(0, 3) == 0);
    arb_if.rd_end   = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    arb_if.init_end = 1'b0;
    arb_if.aref_req = 1'b0; arb_if.aref_end = 1'b0;
    arb_if.wr_req   = 1'b0; arb_if.wr_end   = 1'b0;
    arb_if.rd_req   = 1'b0; arb_if.rd_end   = 1'b0;
    rand_bus();

    // Reset state while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    compare_outputs("reset");
    rst_n = 1'b1;

    // init_end rises at cycle 10 while every engine is already requesting
    for (int cyc = 0; cyc < 14; cyc++) begin
      rand_bus();
      arb_if.init_end = (cyc >= 10);
      arb_if.aref_req = 1'b1; arb_if.wr_req = 1'b1; arb_if.rd_req = 1'b1;
      arb_if.aref_end = (cyc == 12);
      arb_if.wr_end = 1'b0; arb_if.rd_end = 1'b0;
      step("init");
    end

    for (int i = 0; i < 600; i++) begin
      rand_bus();
      rand_ctrl();
      step("rand");
    end

    // Both bursts requested continuously: exercises the wr/rd tie-break
    for (int i = 0; i < 60; i++) begin
      rand_bus();
      arb_if.aref_req = 1'b0;
      arb_if.wr_req = 1'b1; arb_if.rd_req = 1'b1;
      arb_if.aref_end = 1'b1;
      arb_if.wr_end = (i % 3 == 0);
      arb_if.rd_end = (i % 3 == 0);
      step("tie");
    end

    // Drive towards a read burst, then reset asynchronously in the middle of it
    begin
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < 50 && !reached; i++) begin
        rand_bus();
        arb_if.aref_req = 1'b0; arb_if.wr_req = 1'b0; arb_if.rd_req = 1'b1;
        arb_if.aref_end = 1'b1; arb_if.wr_end = 1'b1; arb_if.rd_end = 1'b0;
        step("to_rd");
        reached = (owner == OW_RD);
      end
      chk("reach_read", 32'(reached), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    owner = OW_INIT;
    last_win = OW_RD;
    compare_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_bus();
      rand_ctrl();
      arb_if.init_end = 1'b0;
      step("hold_init");
    end

    for (int i = 0; i < 300; i++) begin
      rand_bus();
      rand_ctrl();
      if (i == 0) arb_if.init_end = 1'b1;
      step("rand2");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
